// File: rtl/dose_alert_ctrl.sv
// dose_alert_ctrl: medication dose alert FSM with debounced acknowledge, miss counting and optional snooze
// Ports: Clk clock; Rst sync active-low reset; Tm_in dose-due pulse; Ack/Snz async buttons;
//        Buzz/Led alert drives; Taken ack pulse; Miss_cnt saturating missed-dose count.
// Optional feature: define DOSE_SNOOZE_EN to enable the snooze button and SNOOZE state.
module dose_deb #(
  parameter int DEB_CYC = 500000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic din,
  output logic ev
);
  localparam int W = $clog2(DEB_CYC + 1);
  localparam logic [W-1:0] MAX = W'(DEB_CYC - 1);
  logic s1, s2, lvl;
  logic [W-1:0] cnt;
  // cnt counts consecutive synchronized cycles that disagree with the accepted level
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == MAX) begin
        lvl <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign ev = s2 && !lvl && cnt == MAX;
endmodule

module dose_alert_ctrl #(
  parameter int ALERT_CYC  = 1000000,
  parameter int BLINK_DIV  = 25000000,
  parameter int DEB_CYC    = 500000,
  parameter int SNOOZE_CYC = 300000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tm_in,
  input  logic       Ack,
  input  logic       Snz,
  output logic       Buzz,
  output logic       Led,
  output logic       Taken,
  output logic [3:0] Miss_cnt
);
  typedef enum logic [1:0] {IDLE, ALERT, SNOOZE} state_t;
  localparam int AW = $clog2(ALERT_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [AW-1:0] A_MAX = AW'(ALERT_CYC - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);
  state_t state;
  logic tm_q, ack_ev, s_to, snz_go, in_alert, in_snz, take, a_to, missed;
  logic [AW-1:0] a_cnt;
  logic [BW-1:0] b_cnt;
  dose_deb #(.DEB_CYC(DEB_CYC)) u_ack (.Clk(Clk), .Rst(Rst), .din(Ack), .ev(ack_ev));
`ifdef DOSE_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_CYC + 1);
  localparam logic [SW-1:0] S_MAX = SW'(SNOOZE_CYC - 1);
  logic snz_ev;
  logic [SW-1:0] s_cnt;
  dose_deb #(.DEB_CYC(DEB_CYC)) u_snz (.Clk(Clk), .Rst(Rst), .din(Snz), .ev(snz_ev));
  assign s_to = in_snz && s_cnt == S_MAX;
  assign snz_go = in_alert && snz_ev;
`else
  logic unused_snz;
  assign unused_snz = Snz;
  assign s_to = 1'b0;
  assign snz_go = 1'b0;
`endif
  assign in_alert = state == ALERT;
  assign in_snz = state == SNOOZE;
  assign take = (in_alert || in_snz) && ack_ev;
  assign a_to = in_alert && a_cnt == A_MAX;
  // a new dose while one is pending is a miss unless it was acknowledged in the same cycle
  assign missed = !take && (((in_alert || in_snz) && tm_q) || a_to);
  // Tm_in is registered once so Buzz rises one edge after the dose-due pulse is sampled
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      tm_q <= 1'b0;
      Buzz <= 1'b0;
      Led <= 1'b0;
      Taken <= 1'b0;
      Miss_cnt <= '0;
      a_cnt <= '0;
      b_cnt <= '0;
`ifdef DOSE_SNOOZE_EN
      s_cnt <= '0;
`endif
    end else begin
      tm_q <= Tm_in;
      Taken <= take;
      if (missed && Miss_cnt != 4'hF) Miss_cnt <= Miss_cnt + 4'd1;
      if (tm_q || (s_to && !take)) begin
        state <= ALERT;
        a_cnt <= '0;
        b_cnt <= '0;
        Buzz <= 1'b1;
        Led <= 1'b1;
      end else if (take || a_to) begin
        state <= IDLE;
        Buzz <= 1'b0;
        Led <= 1'b0;
      end else if (snz_go) begin
        state <= SNOOZE;
        Buzz <= 1'b0;
        Led <= 1'b1;
`ifdef DOSE_SNOOZE_EN
        s_cnt <= '0;
`endif
      end else if (in_alert) begin
        a_cnt <= a_cnt + 1'b1;
        b_cnt <= (b_cnt == B_MAX) ? '0 : b_cnt + 1'b1;
        Led <= (b_cnt == B_MAX) ? ~Led : Led;
      end
`ifdef DOSE_SNOOZE_EN
      else if (in_snz) s_cnt <= s_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_dose_alert_ctrl.sv
// tb_dose_alert_ctrl: directed self-checking bench for dose_alert_ctrl
module tb_dose_alert_ctrl;
  logic Clk = 1'b0, Rst = 1'b0, Tm_in = 1'b0, Ack = 1'b0, Snz = 1'b0;
  logic Buzz, Led, Taken;
  logic [3:0] Miss_cnt;
  int n_cmp = 0, n_bad = 0;
  dose_alert_ctrl #(.ALERT_CYC(100), .BLINK_DIV(4), .DEB_CYC(3), .SNOOZE_CYC(50)) dut (
    .Clk(Clk), .Rst(Rst), .Tm_in(Tm_in), .Ack(Ack), .Snz(Snz),
    .Buzz(Buzz), .Led(Led), .Taken(Taken), .Miss_cnt(Miss_cnt)
  );
  always #5 Clk = ~Clk;
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset();
    Rst = 1'b0; Tm_in = 1'b0; Ack = 1'b0; Snz = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask
  task automatic pulse_tm();
    Tm_in = 1'b1;
    step();
    Tm_in = 1'b0;
    step();
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if (Buzz !== 1'b0) begin n_bad++; $display("FAIL reset_buzz got %b want 0", Buzz); end
    n_cmp++; if (Led !== 1'b0) begin n_bad++; $display("FAIL reset_led got %b want 0", Led); end
    n_cmp++; if (Taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got %b want 0", Taken); end
    n_cmp++; if (Miss_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_miss got %0d want 0", Miss_cnt); end
  endtask
  task automatic test_timeout();
    do_reset();
    pulse_tm();
    for (int i = 0; i < 100; i++) begin
      logic el;
      el = ((i / 4) % 2) == 0;
      n_cmp++; if (Buzz !== 1'b1 || Led !== el) begin n_bad++; $display("FAIL timeout_alert i=%0d got buzz=%b led=%b want 1 %b", i, Buzz, Led, el); end
      step();
    end
    n_cmp++; if (Buzz !== 1'b0 || Led !== 1'b0) begin n_bad++; $display("FAIL timeout_idle got buzz=%b led=%b want 0 0", Buzz, Led); end
    n_cmp++; if (Miss_cnt !== 4'd1) begin n_bad++; $display("FAIL timeout_miss got %0d want 1", Miss_cnt); end
  endtask
  task automatic test_ack();
    int pulses;
    do_reset();
    pulse_tm();
    repeat (20) step();
    Ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++; if (Taken !== (k == 5) || Buzz !== (k < 5)) begin n_bad++; $display("FAIL ack_seq k=%0d got taken=%b buzz=%b want %b %b", k, Taken, Buzz, k == 5, k < 5); end
    end
    Ack = 1'b0;
    pulses = 0;
    repeat (10) begin step(); pulses += int'(Taken); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL ack_extra_taken got %0d want 0", pulses); end
    n_cmp++; if (Buzz !== 1'b0 || Miss_cnt !== 4'd0) begin n_bad++; $display("FAIL ack_after got buzz=%b miss=%0d want 0 0", Buzz, Miss_cnt); end
  endtask
  task automatic test_glitch();
    do_reset();
    pulse_tm();
    repeat (5) step();
    Ack = 1'b1;
    step();
    step();
    Ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (Taken !== 1'b0 || Buzz !== 1'b1) begin n_bad++; $display("FAIL glitch k=%0d got taken=%b buzz=%b want 0 1", k, Taken, Buzz); end
    end
  endtask
  task automatic test_tm_ack_same();
    do_reset();
    pulse_tm();
    repeat (10) step();
    Ack = 1'b1;
    repeat (3) step();
    Tm_in = 1'b1;
    step();
    Tm_in = 1'b0;
    step();
    Ack = 1'b0;
    n_cmp++; if (Taken !== 1'b1 || Buzz !== 1'b1 || Led !== 1'b1) begin n_bad++; $display("FAIL same_taken got taken=%b buzz=%b led=%b want 1 1 1", Taken, Buzz, Led); end
    n_cmp++; if (Miss_cnt !== 4'd0) begin n_bad++; $display("FAIL same_miss got %0d want 0", Miss_cnt); end
    repeat (99) step();
    n_cmp++; if (Buzz !== 1'b1) begin n_bad++; $display("FAIL same_restart got buzz=%b want 1", Buzz); end
    step();
    n_cmp++; if (Buzz !== 1'b0 || Miss_cnt !== 4'd1) begin n_bad++; $display("FAIL same_timeout got buzz=%b miss=%0d want 0 1", Buzz, Miss_cnt); end
  endtask
  task automatic test_saturate();
    do_reset();
    for (int j = 0; j < 20; j++) begin
      logic [3:0] em;
      em = (j > 15) ? 4'd15 : 4'(j);
      Tm_in = 1'b1;
      step();
      Tm_in = 1'b0;
      step();
      n_cmp++; if (Miss_cnt !== em || Led !== 1'b1 || Buzz !== 1'b1) begin n_bad++; $display("FAIL sat_pulse j=%0d got miss=%0d led=%b buzz=%b want %0d 1 1", j, Miss_cnt, Led, Buzz, em); end
      repeat (8) step();
    end
    repeat (100) step();
    n_cmp++; if (Miss_cnt !== 4'd15 || Buzz !== 1'b0) begin n_bad++; $display("FAIL sat_final got miss=%0d buzz=%b want 15 0", Miss_cnt, Buzz); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    pulse_tm();
    repeat (10) step();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    n_cmp++; if (Buzz !== 1'b0 || Led !== 1'b0 || Taken !== 1'b0 || Miss_cnt !== 4'd0) begin n_bad++; $display("FAIL rstmid got buzz=%b led=%b taken=%b miss=%0d want 0 0 0 0", Buzz, Led, Taken, Miss_cnt); end
    Rst = 1'b0;
    Tm_in = 1'b1;
    step();
    Rst = 1'b1;
    Tm_in = 1'b0;
    step();
    step();
    n_cmp++; if (Buzz !== 1'b0) begin n_bad++; $display("FAIL rst_priority got buzz=%b want 0", Buzz); end
    pulse_tm();
    n_cmp++; if (Buzz !== 1'b1) begin n_bad++; $display("FAIL rst_recover got buzz=%b want 1", Buzz); end
  endtask
`ifdef DOSE_SNOOZE_EN
  task automatic test_snooze();
    do_reset();
    pulse_tm();
    repeat (5) step();
    Snz = 1'b1;
    repeat (5) step();
    Snz = 1'b0;
    for (int i = 0; i < 50; i++) begin
      n_cmp++; if (Buzz !== 1'b0 || Led !== 1'b1) begin n_bad++; $display("FAIL snooze_hold i=%0d got buzz=%b led=%b want 0 1", i, Buzz, Led); end
      step();
    end
    n_cmp++; if (Buzz !== 1'b1 || Led !== 1'b1) begin n_bad++; $display("FAIL snooze_expire got buzz=%b led=%b want 1 1", Buzz, Led); end
    do_reset();
    pulse_tm();
    Snz = 1'b1;
    repeat (5) step();
    Snz = 1'b0;
    repeat (5) step();
    Ack = 1'b1;
    repeat (5) step();
    Ack = 1'b0;
    n_cmp++; if (Taken !== 1'b1 || Buzz !== 1'b0 || Led !== 1'b0) begin n_bad++; $display("FAIL snooze_ack got taken=%b buzz=%b led=%b want 1 0 0", Taken, Buzz, Led); end
    n_cmp++; if (Miss_cnt !== 4'd0) begin n_bad++; $display("FAIL snooze_miss got %0d want 0", Miss_cnt); end
  endtask
`else
  task automatic test_snz_ignored();
    do_reset();
    pulse_tm();
    Snz = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) Snz = 1'b0;
      step();
      n_cmp++; if (Buzz !== 1'b1 || Taken !== 1'b0) begin n_bad++; $display("FAIL snz_ignored k=%0d got buzz=%b taken=%b want 1 0", k, Buzz, Taken); end
    end
  endtask
`endif
  initial begin
    test_reset();
    test_timeout();
    test_ack();
    test_glitch();
    test_tm_ack_same();
    test_saturate();
    test_reset_mid();
`ifdef DOSE_SNOOZE_EN
    test_snooze();
`else
    test_snz_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dose_alert_ctrl.md
DOSE_ALERT_CTRL -- requirements
Module: dose_alert_ctrl

Interface
REQ-001 Parameter ALERT_CYC, default 1000000: cycles an alert may stay unacknowledged before the dose counts as missed.
REQ-002 Parameter BLINK_DIV, default 25000000: Led half-period in cycles while alerting.
REQ-003 Parameter DEB_CYC, default 500000: consecutive stable synchronized cycles required to accept a button edge.
REQ-004 Parameter SNOOZE_CYC, default 300000000: snooze duration in cycles.
REQ-005 Clk  input  1  single clock; all logic is on the rising edge.
REQ-006 Rst  input  1  reset; synchronous, active-low.
REQ-007 Tm_in  input  1  dose-due pulse from the upstream timer output; one cycle wide, synchronous to Clk.
REQ-008 Ack  input  1  "dose taken" button; asynchronous, active-high.
REQ-009 Snz  input  1  snooze button; asynchronous, active-high; ignored unless DOSE_SNOOZE_EN is defined.
REQ-010 Buzz  output  1  buzzer drive.
REQ-011 Led  output  1  indicator LED drive.
REQ-012 Taken  output  1  one-cycle pulse on each accepted acknowledgement.
REQ-013 Miss_cnt  output  4  count of missed doses, saturating.

Function
REQ-014 Ack and Snz each pass through a 2-flop synchronizer and then a debouncer.
REQ-015 A debounced press event is raised once, when the synchronized level has been high for DEB_CYC consecutive cycles; a new event requires DEB_CYC consecutive low cycles first.
REQ-016 States: IDLE, ALERT, SNOOZE; all outputs are registered.
REQ-017 IDLE: Buzz=0, Led=0; Tm_in=1 -> ALERT with the alert counter cleared; the button events have no effect.
REQ-018 ALERT: Buzz=1; Led=1 on entry and toggles every BLINK_DIV cycles.
REQ-019 Tm_in sampled high at edge N gives Buzz=1 after edge N+1.
REQ-020 ALERT + Ack event -> IDLE; Taken=1 for exactly one cycle, coincident with the first IDLE cycle.
REQ-021 ALERT + alert counter reaching ALERT_CYC-1 without an Ack event -> IDLE; Miss_cnt increments.
REQ-022 An Ack event and the timeout in the same cycle resolve as taken; no miss is recorded.
REQ-023 Tm_in=1 while in ALERT or SNOOZE: Miss_cnt increments; the state becomes ALERT with the counters restarted and Led=1.
REQ-024 Miss_cnt saturates at 15 and never wraps.
REQ-025 Tm_in and an Ack event in the same cycle while in ALERT: Ack takes priority (Taken pulse); the state then becomes ALERT for the new dose with no miss recorded.
REQ-026 SNOOZE: Buzz=0, Led=1 steady.
REQ-027 SNOOZE + Ack event -> IDLE with a Taken pulse.
REQ-028 SNOOZE + SNOOZE_CYC cycles elapsed -> ALERT with the alert counter cleared.
REQ-029 Every counter width is at least clog2 of its parameter, and no counter overflows.

Reset
REQ-030 Rst=0 at a rising edge forces: IDLE, Buzz=0, Led=0, Taken=0, Miss_cnt=0, all counters and the debouncer state =0, synchronizer flops =0.
REQ-031 Reset mid-ALERT or mid-SNOOZE discards the pending dose without recording a miss.
REQ-032 Reset takes priority over every other input.

Configuration
REQ-033 With macro DOSE_SNOOZE_EN defined: ALERT + Snz event -> SNOOZE.
REQ-034 If an Ack event and a Snz event occur in the same cycle, Ack wins.
REQ-035 Without DOSE_SNOOZE_EN: the Snz port exists but is unused; no snooze counter or Snz debouncer is synthesized, and SNOOZE is unreachable.

Verification (ALERT_CYC=100, BLINK_DIV=4, DEB_CYC=3, SNOOZE_CYC=50)
REQ-036 Rst=0 for 2 cycles, then 1 -> Buzz=0, Led=0, Miss_cnt=0, Taken=0.
REQ-037 Tm_in pulse, no Ack -> Buzz=1 for 100 cycles; Led toggles every 4 cycles; then Buzz=0 and Miss_cnt=1.
REQ-038 Tm_in pulse, then Ack held high 10 cycles starting at cycle 20 -> exactly one Taken pulse; Buzz=0 afterwards; Miss_cnt unchanged.
REQ-039 Ack glitch of 2 cycles during ALERT -> no Taken pulse; alert continues.
REQ-040 16 unacknowledged Tm_in pulses, each 10 cycles apart -> Miss_cnt=15 after the last pulse, with no wrap.
REQ-041 With DOSE_SNOOZE_EN: Snz held 5 cycles in ALERT -> Buzz=0, Led=1 for 50 cycles, then Buzz=1 for up to 100 cycles; Ack in SNOOZE -> Taken pulse, IDLE.
